// File: rtl/ffo_scanner_if.sv
// Vector-in / position-out handshake bundle for the find-first-one scanner.
// Master is the producer+consumer side, slave is the scanner.
interface ffo_scanner_if #(
    parameter int WIDTH = 16
);
    localparam int POS_W = $clog2(WIDTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_vec;
    logic             in_dir;
    logic             out_valid;
    logic             out_ready;
    logic [POS_W-1:0] out_pos;
    logic             out_last;

    modport master (
        output in_valid, in_vec, in_dir, out_ready,
        input  in_ready, out_valid, out_pos, out_last
    );

    modport slave (
        input  in_valid, in_vec, in_dir, out_ready,
        output in_ready, out_valid, out_pos, out_last
    );
endinterface

// File: rtl/ffo_scanner.sv
// Emits the 1-based index of every set bit of a vector, MSB- or LSB-first, one per beat.
// First beat one cycle after accept; beats hold under backpressure, next vector accepted on the last beat.
module ffo_scanner #(
    parameter int WIDTH = 16
) (
    input logic           clk,
    input logic           rst_n,
    ffo_scanner_if.slave  bus
);
    localparam int POS_W = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] pend, pend_nxt;
    logic             dir, dir_nxt;

    logic [POS_W-1:0] hi_pos, lo_pos, sel_pos;
    logic [WIDTH-1:0] hi_mask, lo_mask, sel_mask;
    logic             at_most_one;
    logic             in_fire, out_fire;

    // Priority encoders in both directions; the last match in each loop wins.
    always_comb begin
        hi_pos  = '0;
        hi_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (pend[i]) begin
                hi_pos     = POS_W'(i + 1);
                hi_mask    = '0;
                hi_mask[i] = 1'b1;
            end
        end
        lo_pos  = '0;
        lo_mask = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pend[i]) begin
                lo_pos     = POS_W'(i + 1);
                lo_mask    = '0;
                lo_mask[i] = 1'b1;
            end
        end
    end

    assign sel_pos     = dir ? lo_pos  : hi_pos;
    assign sel_mask    = dir ? lo_mask : hi_mask;
    assign at_most_one = (pend & (pend - WIDTH'(1))) == '0;

    assign bus.out_valid = (state == EMIT);
    assign bus.out_pos   = (state == EMIT) ? sel_pos : '0;
    assign bus.out_last  = (state == EMIT) & at_most_one;

    assign out_fire     = bus.out_valid & bus.out_ready;
    assign bus.in_ready = rst_n & ((state == IDLE) | (out_fire & bus.out_last));
    assign in_fire      = bus.in_valid & bus.in_ready;

    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        dir_nxt   = dir;
        case (state)
            IDLE: begin
                if (in_fire) begin
                    pend_nxt  = bus.in_vec;
                    dir_nxt   = bus.in_dir;
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (out_fire) begin
                    if (!bus.out_last) begin
                        pend_nxt = pend & ~sel_mask;
                    end else if (in_fire) begin
                        pend_nxt = bus.in_vec;
                        dir_nxt  = bus.in_dir;
                    end else begin
                        pend_nxt  = '0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            pend  <= '0;
            dir   <= 1'b0;
        end else begin
            state <= state_nxt;
            pend  <= pend_nxt;
            dir   <= dir_nxt;
        end
    end
endmodule

// File: tb/tb_ffo_scanner.sv
// Directed bench for ffo_scanner at WIDTH 8 and WIDTH 16.
module tb_ffo_scanner;
    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    ffo_scanner_if #(.WIDTH(8))  b8 ();
    ffo_scanner_if #(.WIDTH(16)) b16 ();

    ffo_scanner #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
    ffo_scanner #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        @(negedge clk);
        tests++;
        if (b8.in_ready !== 1'b0) begin
            fails++; $display("FAIL reset_in_ready_low got=%b exp=0", b8.in_ready);
        end
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (b8.out_valid !== 1'b0 || b8.out_pos !== 4'd0 || b8.out_last !== 1'b0) begin
            fails++; $display("FAIL reset_outputs got v=%b p=%0d l=%b exp v=0 p=0 l=0",
                              b8.out_valid, b8.out_pos, b8.out_last);
        end
        tests++;
        if (b8.in_ready !== 1'b1) begin
            fails++; $display("FAIL reset_in_ready_high got=%b exp=1", b8.in_ready);
        end
        cyc();
    endtask

    task automatic test_patterns();
        logic [7:0] vecs [4] = '{8'hA4, 8'hA4, 8'h00, 8'h01};
        logic       dirs [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        int         nb   [4] = '{3, 3, 1, 1};
        int         exp  [4][3] = '{'{8, 6, 3}, '{3, 6, 8}, '{0, 0, 0}, '{1, 0, 0}};
        for (int k = 0; k < 4; k++) begin
            b8.in_valid  = 1'b1;
            b8.in_vec    = vecs[k];
            b8.in_dir    = dirs[k];
            b8.out_ready = 1'b1;
            @(negedge clk);
            tests++;
            if (b8.in_ready !== 1'b1) begin
                fails++; $display("FAIL pat%0d_accept in_ready got=%b exp=1", k, b8.in_ready);
            end
            cyc();
            b8.in_valid = 1'b0;
            b8.in_vec   = 8'h55;
            b8.in_dir   = ~dirs[k];
            for (int b = 0; b < nb[k]; b++) begin
                @(negedge clk);
                tests++;
                if (b8.out_valid !== 1'b1 || b8.out_pos !== 4'(exp[k][b]) ||
                    b8.out_last !== (b == nb[k] - 1)) begin
                    fails++; $display("FAIL pat%0d_beat%0d got v=%b p=%0d l=%b exp v=1 p=%0d l=%b",
                                      k, b, b8.out_valid, b8.out_pos, b8.out_last,
                                      exp[k][b], (b == nb[k] - 1));
                end
                if (b == nb[k] - 1) begin
                    tests++;
                    if (b8.in_ready !== 1'b1) begin
                        fails++; $display("FAIL pat%0d_last_in_ready got=%b exp=1", k, b8.in_ready);
                    end
                end
                cyc();
            end
            @(negedge clk);
            tests++;
            if (b8.out_valid !== 1'b0) begin
                fails++; $display("FAIL pat%0d_idle out_valid got=%b exp=0", k, b8.out_valid);
            end
            cyc();
        end
    endtask

    task automatic test_backpressure();
        b8.in_valid  = 1'b1;
        b8.in_vec    = 8'hC0;
        b8.in_dir    = 1'b0;
        b8.out_ready = 1'b0;
        cyc();
        b8.in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            b8.in_vec = 8'(c + 1);
            @(negedge clk);
            tests++;
            if (b8.out_valid !== 1'b1 || b8.out_pos !== 4'd8 || b8.out_last !== 1'b0 ||
                b8.in_ready !== 1'b0) begin
                fails++; $display("FAIL bp_hold%0d got v=%b p=%0d l=%b r=%b exp v=1 p=8 l=0 r=0",
                                  c, b8.out_valid, b8.out_pos, b8.out_last, b8.in_ready);
            end
            cyc();
        end
        b8.out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (b8.out_pos !== 4'd8 || b8.out_last !== 1'b0) begin
            fails++; $display("FAIL bp_beat0 got p=%0d l=%b exp p=8 l=0", b8.out_pos, b8.out_last);
        end
        cyc();
        @(negedge clk);
        tests++;
        if (b8.out_valid !== 1'b1 || b8.out_pos !== 4'd7 || b8.out_last !== 1'b1) begin
            fails++; $display("FAIL bp_beat1 got v=%b p=%0d l=%b exp v=1 p=7 l=1",
                              b8.out_valid, b8.out_pos, b8.out_last);
        end
        cyc();
        @(negedge clk);
        tests++;
        if (b8.out_valid !== 1'b0) begin
            fails++; $display("FAIL bp_no_extra out_valid got=%b exp=0", b8.out_valid);
        end
        cyc();
    endtask

    task automatic test_back_to_back();
        int exp_pos  [4] = '{8, 1, 5, 4};
        logic exp_lst[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic exp_rdy[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        b8.in_valid  = 1'b1;
        b8.in_vec    = 8'h81;
        b8.in_dir    = 1'b0;
        b8.out_ready = 1'b1;
        cyc();
        b8.in_vec = 8'h18;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            tests++;
            if (b8.out_valid !== 1'b1 || b8.out_pos !== 4'(exp_pos[b]) ||
                b8.out_last !== exp_lst[b] || b8.in_ready !== exp_rdy[b]) begin
                fails++; $display("FAIL b2b_beat%0d got v=%b p=%0d l=%b r=%b exp v=1 p=%0d l=%b r=%b",
                                  b, b8.out_valid, b8.out_pos, b8.out_last, b8.in_ready,
                                  exp_pos[b], exp_lst[b], exp_rdy[b]);
            end
            cyc();
            if (b == 1) b8.in_valid = 1'b0;
        end
        @(negedge clk);
        tests++;
        if (b8.out_valid !== 1'b0) begin
            fails++; $display("FAIL b2b_idle out_valid got=%b exp=0", b8.out_valid);
        end
        cyc();
    endtask

    task automatic test_reset_mid_scan();
        b8.in_valid  = 1'b1;
        b8.in_vec    = 8'hFF;
        b8.in_dir    = 1'b1;
        b8.out_ready = 1'b1;
        cyc();
        b8.in_valid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            tests++;
            if (b8.out_pos !== 4'(b + 1) || b8.out_last !== 1'b0) begin
                fails++; $display("FAIL rst_beat%0d got p=%0d l=%b exp p=%0d l=0",
                                  b, b8.out_pos, b8.out_last, b + 1);
            end
            cyc();
        end
        rst_n = 1'b0;
        @(negedge clk);
        tests++;
        if (b8.in_ready !== 1'b0) begin
            fails++; $display("FAIL rst_in_ready_during got=%b exp=0", b8.in_ready);
        end
        cyc();
        @(negedge clk);
        tests++;
        if (b8.out_valid !== 1'b0 || b8.in_ready !== 1'b0) begin
            fails++; $display("FAIL rst_after got v=%b r=%b exp v=0 r=0", b8.out_valid, b8.in_ready);
        end
        cyc();
        rst_n = 1'b1;
        b8.in_valid = 1'b1;
        b8.in_vec   = 8'h02;
        b8.in_dir   = 1'b0;
        cyc();
        b8.in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (b8.out_valid !== 1'b1 || b8.out_pos !== 4'd2 || b8.out_last !== 1'b1) begin
            fails++; $display("FAIL rst_post_vec got v=%b p=%0d l=%b exp v=1 p=2 l=1",
                              b8.out_valid, b8.out_pos, b8.out_last);
        end
        cyc();
        @(negedge clk);
        tests++;
        if (b8.out_valid !== 1'b0) begin
            fails++; $display("FAIL rst_post_idle out_valid got=%b exp=0", b8.out_valid);
        end
        cyc();
    endtask

    task automatic test_wide_all_ones();
        b16.in_valid  = 1'b1;
        b16.in_vec    = 16'hFFFF;
        b16.in_dir    = 1'b0;
        b16.out_ready = 1'b1;
        cyc();
        b16.in_valid = 1'b0;
        for (int b = 0; b < 16; b++) begin
            @(negedge clk);
            tests++;
            if (b16.out_valid !== 1'b1 || b16.out_pos !== 5'(16 - b) || b16.out_last !== (b == 15)) begin
                fails++; $display("FAIL wide_beat%0d got v=%b p=%0d l=%b exp v=1 p=%0d l=%b",
                                  b, b16.out_valid, b16.out_pos, b16.out_last, 16 - b, (b == 15));
            end
            cyc();
        end
        @(negedge clk);
        tests++;
        if (b16.out_valid !== 1'b0) begin
            fails++; $display("FAIL wide_idle out_valid got=%b exp=0", b16.out_valid);
        end
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        b8.in_valid   = 1'b0;
        b8.in_vec     = '0;
        b8.in_dir     = 1'b0;
        b8.out_ready  = 1'b0;
        b16.in_valid  = 1'b0;
        b16.in_vec    = '0;
        b16.in_dir    = 1'b0;
        b16.out_ready = 1'b0;
        test_reset();
        test_patterns();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_scan();
        test_wide_all_ones();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
